// File: rtl/fp_add_pipe_if.sv
// Stream interface for fp_add_pipe: operand beat in, packed result plus exception flags out.
interface fp_add_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic         underflow;
   logic         invalid;
   logic         inf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, zero, overflow, underflow, invalid, inf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, zero, overflow, underflow, invalid, inf
   );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage parametrised floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero of subnormals and full special-value handling.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_add_pipe_if.slave bus
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 4;
   localparam int EW    = EXP_W + 2;
   localparam int LZC_W = $clog2(SIG_W + 1);

   localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
   localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [EW-1:0] EXP_MAX_S = {2'b00, EXP_ONES};
   localparam logic signed [EW-1:0] EXP_ZERO_S = {EW{1'b0}};

   function automatic logic [LZC_W-1:0] lzc_f(input logic [SIG_W-1:0] v);
      logic [LZC_W-1:0] n;
      logic             found;
      n     = {LZC_W{1'b0}};
      found = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + LZC_W'(1);
         end else begin
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic stall_s, adv_s;
   assign stall_s      = bus.out_valid & ~bus.out_ready;
   assign adv_s        = ~stall_s;
   assign bus.in_ready = adv_s;

   // ---------------- S1: unpack, classify, swap, align ----------------
   logic             sa_s, sb_s, sx_s, sy_s;
   logic [EXP_W-1:0] ea_s, eb_s, ex_s, ey_s, d_s;
   logic [MAN_W-1:0] ma_s, mb_s, mx_s, my_s;
   logic             a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
   logic             spec_s, spec_zero_s, spec_inf_s, spec_inv_s;
   logic [W-1:0]     spec_res_s;
   logic [2*SIG_W-1:0] ext_s;
   logic [SIG_W-1:0] sig_y_s;

   assign sa_s = bus.a[W-1];
   assign ea_s = bus.a[W-2:MAN_W];
   assign ma_s = bus.a[MAN_W-1:0];
   assign sb_s = bus.b[W-1] ^ bus.sub;
   assign eb_s = bus.b[W-2:MAN_W];
   assign mb_s = bus.b[MAN_W-1:0];

   assign a_zero_s = (ea_s == {EXP_W{1'b0}});
   assign b_zero_s = (eb_s == {EXP_W{1'b0}});
   assign a_inf_s  = (ea_s == EXP_ONES) && (ma_s == {MAN_W{1'b0}});
   assign b_inf_s  = (eb_s == EXP_ONES) && (mb_s == {MAN_W{1'b0}});
   assign a_nan_s  = (ea_s == EXP_ONES) && (ma_s != {MAN_W{1'b0}});
   assign b_nan_s  = (eb_s == EXP_ONES) && (mb_s != {MAN_W{1'b0}});

   // Special-value result, resolved in priority order
   always_comb begin
      spec_s      = 1'b1;
      spec_res_s  = {W{1'b0}};
      spec_zero_s = 1'b0;
      spec_inf_s  = 1'b0;
      spec_inv_s  = 1'b0;
      if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
         spec_res_s = QNAN;
         spec_inv_s = 1'b1;
      end else if (a_inf_s || b_inf_s) begin
         spec_res_s = {(a_inf_s ? sa_s : sb_s), EXP_ONES, {MAN_W{1'b0}}};
         spec_inf_s = 1'b1;
      end else if (a_zero_s && b_zero_s) begin
         spec_res_s  = {sa_s & sb_s, {(W-1){1'b0}}};
         spec_zero_s = 1'b1;
      end else if (a_zero_s) begin
         spec_res_s = {sb_s, eb_s, mb_s};
      end else if (b_zero_s) begin
         spec_res_s = bus.a;
      end else begin
         spec_s = 1'b0;
      end
   end

   // Order operands by magnitude so the subtraction never goes negative
   always_comb begin
      if ({ea_s, ma_s} >= {eb_s, mb_s}) begin
         sx_s = sa_s; ex_s = ea_s; mx_s = ma_s;
         sy_s = sb_s; ey_s = eb_s; my_s = mb_s;
      end else begin
         sx_s = sb_s; ex_s = eb_s; mx_s = mb_s;
         sy_s = sa_s; ey_s = ea_s; my_s = ma_s;
      end
   end

   assign d_s   = ex_s - ey_s;
   assign ext_s = {1'b1, my_s, 3'b000, {SIG_W{1'b0}}} >> d_s;

   // Align the smaller significand; everything shifted out folds into sticky
   always_comb begin
      if (32'(d_s) > 32'(MAN_W + 3)) begin
         sig_y_s = {{(SIG_W-1){1'b0}}, 1'b1};
      end else begin
         sig_y_s = ext_s[2*SIG_W-1:SIG_W] | {{(SIG_W-1){1'b0}}, |ext_s[SIG_W-1:0]};
      end
   end

   logic             s1_valid_r, s1_spec_r, s1_sign_r, s1_eff_sub_r;
   logic [2:0]       s1_spec_flags_r;
   logic [W-1:0]     s1_spec_res_r;
   logic [EXP_W-1:0] s1_exp_r;
   logic [SIG_W-1:0] s1_sig_x_r, s1_sig_y_r;

   // S1 pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r      <= 1'b0;
         s1_spec_r       <= 1'b0;
         s1_spec_flags_r <= 3'b000;
         s1_spec_res_r   <= {W{1'b0}};
         s1_sign_r       <= 1'b0;
         s1_eff_sub_r    <= 1'b0;
         s1_exp_r        <= {EXP_W{1'b0}};
         s1_sig_x_r      <= {SIG_W{1'b0}};
         s1_sig_y_r      <= {SIG_W{1'b0}};
      end else if (adv_s) begin
         s1_valid_r      <= bus.in_valid;
         s1_spec_r       <= spec_s;
         s1_spec_flags_r <= {spec_zero_s, spec_inf_s, spec_inv_s};
         s1_spec_res_r   <= spec_res_s;
         s1_sign_r       <= sx_s;
         s1_eff_sub_r    <= sx_s ^ sy_s;
         s1_exp_r        <= ex_s;
         s1_sig_x_r      <= {1'b1, mx_s, 3'b000};
         s1_sig_y_r      <= sig_y_s;
      end
   end

   // ---------------- S2: add/sub, LZC, normalise ----------------
   logic [SIG_W:0]          sum_s;
   logic [LZC_W-1:0]        lz_s;
   logic [SIG_W-1:0]        norm_sig_s;
   logic signed [EW-1:0]    norm_exp_s;

   assign sum_s = s1_eff_sub_r ? ({1'b0, s1_sig_x_r} - {1'b0, s1_sig_y_r})
                               : ({1'b0, s1_sig_x_r} + {1'b0, s1_sig_y_r});
   assign lz_s  = lzc_f(sum_s[SIG_W-1:0]);

   // Carry out shifts right by one, otherwise shift the leading one up to the hidden position
   always_comb begin
      if (sum_s[SIG_W]) begin
         norm_sig_s = {sum_s[SIG_W:2], sum_s[1] | sum_s[0]};
         norm_exp_s = $signed({2'b00, s1_exp_r}) + EW'(1);
      end else begin
         norm_sig_s = sum_s[SIG_W-1:0] << lz_s;
         norm_exp_s = $signed({2'b00, s1_exp_r}) - $signed(EW'(lz_s));
      end
   end

   logic                 s2_valid_r, s2_spec_r, s2_sign_r, s2_zero_r;
   logic [2:0]           s2_spec_flags_r;
   logic [W-1:0]         s2_spec_res_r;
   logic signed [EW-1:0] s2_exp_r;
   logic [SIG_W-1:0]     s2_sig_r;

   // S2 pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r      <= 1'b0;
         s2_spec_r       <= 1'b0;
         s2_spec_flags_r <= 3'b000;
         s2_spec_res_r   <= {W{1'b0}};
         s2_sign_r       <= 1'b0;
         s2_zero_r       <= 1'b0;
         s2_exp_r        <= {EW{1'b0}};
         s2_sig_r        <= {SIG_W{1'b0}};
      end else if (adv_s) begin
         s2_valid_r      <= s1_valid_r;
         s2_spec_r       <= s1_spec_r;
         s2_spec_flags_r <= s1_spec_flags_r;
         s2_spec_res_r   <= s1_spec_res_r;
         s2_sign_r       <= s1_sign_r;
         s2_zero_r       <= (sum_s == {(SIG_W+1){1'b0}});
         s2_exp_r        <= norm_exp_s;
         s2_sig_r        <= norm_sig_s;
      end
   end

   // ---------------- S3: round, exceptions, pack ----------------
   logic                 rnd_up_s;
   logic [MAN_W+1:0]     rounded_s;
   logic [MAN_W-1:0]     man_out_s;
   logic signed [EW-1:0] rnd_exp_s;
   logic [W-1:0]         res_s;
   logic                 zero_s, ovf_s, unf_s, inv_s, inf_s;

   assign rnd_up_s  = s2_sig_r[2] & (s2_sig_r[1] | s2_sig_r[0] | s2_sig_r[3]);
   assign rounded_s = {1'b0, s2_sig_r[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};

   // Rounding carry renormalises by bumping the exponent
   always_comb begin
      if (rounded_s[MAN_W+1]) begin
         man_out_s = rounded_s[MAN_W:1];
         rnd_exp_s = s2_exp_r + EW'(1);
      end else begin
         man_out_s = rounded_s[MAN_W-1:0];
         rnd_exp_s = s2_exp_r;
      end
   end

   // Final result selection and exception flags
   always_comb begin
      res_s  = {W{1'b0}};
      zero_s = 1'b0;
      ovf_s  = 1'b0;
      unf_s  = 1'b0;
      inv_s  = 1'b0;
      inf_s  = 1'b0;
      if (s2_spec_r) begin
         res_s  = s2_spec_res_r;
         zero_s = s2_spec_flags_r[2];
         inf_s  = s2_spec_flags_r[1];
         inv_s  = s2_spec_flags_r[0];
      end else if (s2_zero_r) begin
         zero_s = 1'b1;
      end else if (rnd_exp_s >= EXP_MAX_S) begin
         res_s = {s2_sign_r, EXP_ONES, {MAN_W{1'b0}}};
         ovf_s = 1'b1;
         inf_s = 1'b1;
      end else if (rnd_exp_s <= EXP_ZERO_S) begin
         res_s  = {s2_sign_r, {(W-1){1'b0}}};
         unf_s  = 1'b1;
         zero_s = 1'b1;
      end else begin
         res_s = {s2_sign_r, rnd_exp_s[EXP_W-1:0], man_out_s};
      end
   end

   logic         out_valid_r, zero_r, ovf_r, unf_r, inv_r, inf_r;
   logic [W-1:0] result_r;

   // Output register; holds steady while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         result_r    <= {W{1'b0}};
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
         inv_r       <= 1'b0;
         inf_r       <= 1'b0;
      end else if (adv_s) begin
         out_valid_r <= s2_valid_r;
         result_r    <= res_s;
         zero_r      <= zero_s;
         ovf_r       <= ovf_s;
         unf_r       <= unf_s;
         inv_r       <= inv_s;
         inf_r       <= inf_s;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.zero      = zero_r;
   assign bus.overflow  = ovf_r;
   assign bus.underflow = unf_r;
   assign bus.invalid   = inv_r;
   assign bus.inf       = inf_r;
endmodule
